// File: rtl/maxpool_scheduler.sv
// maxpool_scheduler
//   Runs one pooling engine over a stack of num_channels square int8 feature
//   maps. Each map is read row-major from the input RAM and fed to the engine
//   one pixel per cycle. Pooled results go to the output RAM. The engine is
//   cleared between channels.
//
//   Optional build macro: MAXPOOL_SCHED_PERF_EN adds the perf_cycles port.
//
//   Ports
//     clk, rst           clock, synchronous active-high reset
//     start              begin a run (sampled in IDLE only)
//     num_channels       channel count, latched on an accepted start
//     busy, done, err    run status, one-cycle done pulse, sticky error
//     rd_en/addr/data    input RAM read port (data valid one cycle after rd_en)
//     eng_*              pooling engine control, stream in, results out
//     wr_en/addr/data    output RAM write port
//     perf_cycles        (MAXPOOL_SCHED_PERF_EN only) cycle count of last run
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | waiting for start
//   CLEAR  | one-cycle engine reset before each channel
//   STREAM | reading MAP_WIDTH^2 pixels of the current channel
//   DRAIN  | waiting for the engine to report all outputs done
//   FIN    | done pulse (a zero-channel run spends one extra busy cycle here)
module maxpool_scheduler #(
   parameter int MAP_WIDTH = 28,
   parameter int OUT_DIM   = MAP_WIDTH / 2,
   parameter int MAX_CH    = 16,
   parameter int CH_W      = $clog2(MAX_CH + 1),
   parameter int IN_AW     = $clog2(MAX_CH * MAP_WIDTH * MAP_WIDTH),
   parameter int OUT_AW    = $clog2(MAX_CH * OUT_DIM * OUT_DIM)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CH_W-1:0]   num_channels,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              rd_en,
   output logic [IN_AW-1:0]  rd_addr,
   input  logic [7:0]        rd_data,
   output logic              eng_rst,
   output logic              eng_valid_in,
   output logic [7:0]        eng_pixel_in,
   input  logic              eng_valid_out,
   input  logic [7:0]        eng_pixel_out,
   input  logic              eng_all_done,
   output logic              wr_en,
   output logic [OUT_AW-1:0] wr_addr,
   output logic [7:0]        wr_data
`ifdef MAXPOOL_SCHED_PERF_EN
   ,
   output logic [31:0]       perf_cycles
`endif
);

   localparam int IN_PIX  = MAP_WIDTH * MAP_WIDTH;
   localparam int OUT_PIX = OUT_DIM * OUT_DIM;
   localparam int PIX_W   = $clog2(IN_PIX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_STREAM,
      S_DRAIN,
      S_FIN
   } state_t;

   state_t           state, next_state;
   logic [CH_W-1:0]  num_ch_q;
   logic [CH_W-1:0]  ch_idx;
   logic [PIX_W-1:0] pix_cnt;
   logic [PIX_W-1:0] wr_cnt;
   logic             zero_run;
   logic             last_ch;
   logic             wr_cnt_bad;

   assign last_ch      = (ch_idx == num_ch_q - CH_W'(1));
   // include a write landing in the same cycle that all_done is seen
   assign wr_cnt_bad   = (wr_cnt + PIX_W'(wr_en)) != PIX_W'(OUT_PIX);
   assign eng_rst      = rst || (state == S_CLEAR);
   assign eng_pixel_in = rd_data;
   assign wr_data      = eng_pixel_out;

   always_comb begin
      next_state = state;
      busy       = 1'b0;
      done       = 1'b0;
      rd_en      = 1'b0;
      wr_en      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) next_state = (num_channels == '0) ? S_FIN : S_CLEAR;
         end
         S_CLEAR: begin
            busy       = 1'b1;
            next_state = S_STREAM;
         end
         S_STREAM: begin
            busy  = 1'b1;
            // gated by rst so an abort stops RAM traffic in the same cycle
            rd_en = !rst;
            wr_en = eng_valid_out && !rst;
            if (pix_cnt == '0) next_state = S_DRAIN;
         end
         S_DRAIN: begin
            busy  = 1'b1;
            wr_en = eng_valid_out && !rst;
            if (eng_all_done) next_state = last_ch ? S_FIN : S_CLEAR;
         end
         S_FIN: begin
            busy = zero_run;
            done = !zero_run;
            if (!zero_run) next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         num_ch_q     <= '0;
         ch_idx       <= '0;
         pix_cnt      <= '0;
         wr_cnt       <= '0;
         rd_addr      <= '0;
         wr_addr      <= '0;
         err          <= 1'b0;
         eng_valid_in <= 1'b0;
         zero_run     <= 1'b0;
      end else begin
         state        <= next_state;
         eng_valid_in <= rd_en;
         if (rd_en) rd_addr <= rd_addr + IN_AW'(1);
         if (wr_en) begin
            wr_addr <= wr_addr + OUT_AW'(1);
            wr_cnt  <= wr_cnt + PIX_W'(1);
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  num_ch_q <= num_channels;
                  err      <= 1'b0;
                  ch_idx   <= '0;
                  rd_addr  <= '0;
                  wr_addr  <= '0;
                  zero_run <= (num_channels == '0);
               end
            end
            S_CLEAR: begin
               pix_cnt <= PIX_W'(IN_PIX - 1);
               wr_cnt  <= '0;
            end
            S_STREAM: begin
               if (pix_cnt != '0) pix_cnt <= pix_cnt - PIX_W'(1);
               if (eng_all_done) err <= 1'b1;
            end
            S_DRAIN: begin
               if (eng_all_done) begin
                  if (wr_cnt_bad) err <= 1'b1;
                  if (!last_ch) ch_idx <= ch_idx + CH_W'(1);
               end
            end
            S_FIN: zero_run <= 1'b0;
            default: ;
         endcase
      end
   end

`ifdef MAXPOOL_SCHED_PERF_EN
   // counts every non-IDLE cycle, including the done cycle, so the result
   // equals the start-to-done latency of the run
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cycles <= '0;
      end else if (state == S_IDLE) begin
         if (start) perf_cycles <= '0;
      end else begin
         perf_cycles <= perf_cycles + 32'd1;
      end
   end
`endif

endmodule
